// File: rtl/master_pkg.sv
// rtl/master_pkg.sv - shared types and constants for the serial bus master
package master_pkg;

    localparam int ADDR_W = 16;
    localparam int DATA_W = 8;
    localparam int HDR_W  = ADDR_W + 1;
    localparam int CNT_W  = 5;

    // Terminal bit-counter values: 17 header bits (address + RW), 8 data bits
    localparam logic [CNT_W-1:0] ADDR_LAST = CNT_W'(HDR_W - 1);
    localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(DATA_W - 1);

    typedef enum logic [3:0] {
        IDLE,
        REQ,
        ADDR,
        WAIT_AACK,
        ACK_END,
        WDATA,
        WAIT_DACK,
        RDATA,
        DONE
    } state_t;

endpackage

// File: rtl/master_if.sv
// rtl/master_if.sv - host-side and bus-side signal bundle of the serial bus master
interface master_if
    import master_pkg::*;
();

    logic              m_execute;
    logic              m_hold;
    logic              m_rw;
    logic [ADDR_W-1:0] m_addr;
    logic [DATA_W-1:0] m_din;
    logic [DATA_W-1:0] m_dout;
    logic              m_dvalid;
    logic              m_busy;

    logic              b_grant;
    logic              b_ack;
    logic              b_bus_in;
    logic              b_request;
    logic              b_bus_out;
    logic              b_util;

    modport master (
        input  m_execute, m_hold, m_rw, m_addr, m_din,
        input  b_grant, b_ack, b_bus_in,
        output m_dout, m_dvalid, m_busy,
        output b_request, b_bus_out, b_util
    );

    modport slave (
        output m_execute, m_hold, m_rw, m_addr, m_din,
        output b_grant, b_ack, b_bus_in,
        input  m_dout, m_dvalid, m_busy,
        input  b_request, b_bus_out, b_util
    );

endinterface

// File: rtl/master_shift_reg.sv
// rtl/master_shift_reg.sv - parallel-load / serial-shift register, MSB leaves first
module master_shift_reg #(
    parameter int WIDTH = 17,
    parameter int OUT_W = WIDTH
) (
    input  logic             CLK,
    input  logic             RSTN,
    input  logic             load,
    input  logic             shift,
    input  logic [WIDTH-1:0] par_in,
    input  logic             ser_in,
    output logic [OUT_W-1:0] par_out,
    output logic             ser_out
);

    logic [WIDTH-1:0] sr_q;

    // Load wins over shift; shifting moves toward the MSB and pulls ser_in into bit 0
    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            sr_q <= '0;
        end else if (load) begin
            sr_q <= par_in;
        end else if (shift) begin
            sr_q <= {sr_q[WIDTH-2:0], ser_in};
        end
    end

    assign par_out = sr_q[OUT_W-1:0];
    assign ser_out = sr_q[WIDTH-1];

endmodule

// File: rtl/master.sv
// rtl/master.sv - serial bus master: request/grant, address+RW header, write or read byte
module master
    import master_pkg::*;
(
    input  logic     CLK,
    input  logic     RSTN,
    master_if.master bus
);

    state_t            state_q;
    state_t            state_d;

    logic [ADDR_W-1:0] addr_q;
    logic              rw_q;
    logic [DATA_W-1:0] din_q;
    logic [DATA_W-1:0] dout_q;
    logic [CNT_W-1:0]  cnt_q;

    logic              latch_en;
    logic              cnt_clr;
    logic              cnt_run;
    logic [CNT_W-1:0]  cnt_last;
    logic              dout_load;
    logic              sr_load;
    logic              sr_shift;
    logic [HDR_W-1:0]  sr_par_in;
    logic [DATA_W-2:0] sr_low;
    logic              sr_msb;

    // The same register serialises the header, then the write byte, or collects the read byte
    master_shift_reg #(
        .WIDTH (HDR_W),
        .OUT_W (DATA_W - 1)
    ) u_shift_reg (
        .CLK     (CLK),
        .RSTN    (RSTN),
        .load    (sr_load),
        .shift   (sr_shift),
        .par_in  (sr_par_in),
        .ser_in  (bus.b_bus_in),
        .par_out (sr_low),
        .ser_out (sr_msb)
    );

    // State register
    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state and datapath strobes; losing the grant anywhere on the bus abandons the transfer
    always_comb begin
        state_d   = state_q;
        latch_en  = 1'b0;
        cnt_clr   = 1'b0;
        dout_load = 1'b0;
        sr_load   = 1'b0;
        sr_shift  = 1'b0;
        sr_par_in = '0;
        case (state_q)
            IDLE: begin
                if (bus.m_execute && bus.m_hold) begin
                    latch_en = 1'b1;
                    state_d  = REQ;
                end
            end
            REQ: begin
                if (bus.b_grant) begin
                    cnt_clr   = 1'b1;
                    sr_load   = 1'b1;
                    sr_par_in = {addr_q, rw_q};
                    state_d   = ADDR;
                end
            end
            ADDR: begin
                if (!bus.b_grant) begin
                    state_d = IDLE;
                end else begin
                    sr_shift = 1'b1;
                    if (cnt_q == ADDR_LAST) begin
                        state_d = WAIT_AACK;
                    end
                end
            end
            WAIT_AACK: begin
                if (!bus.b_grant) begin
                    state_d = IDLE;
                end else if (bus.b_ack) begin
                    state_d = ACK_END;
                end
            end
            ACK_END: begin
                if (!bus.b_grant) begin
                    state_d = IDLE;
                end else if (!bus.b_ack) begin
                    cnt_clr = 1'b1;
                    if (rw_q) begin
                        sr_load   = 1'b1;
                        sr_par_in = {din_q, {(HDR_W - DATA_W){1'b0}}};
                        state_d   = WDATA;
                    end else begin
                        state_d = RDATA;
                    end
                end
            end
            WDATA: begin
                if (!bus.b_grant) begin
                    state_d = IDLE;
                end else begin
                    sr_shift = 1'b1;
                    if (cnt_q == DATA_LAST) begin
                        state_d = WAIT_DACK;
                    end
                end
            end
            WAIT_DACK: begin
                if (!bus.b_grant) begin
                    state_d = IDLE;
                end else if (bus.b_ack) begin
                    state_d = DONE;
                end
            end
            RDATA: begin
                if (!bus.b_grant) begin
                    state_d = IDLE;
                end else begin
                    sr_shift = 1'b1;
                    if (cnt_q == DATA_LAST) begin
                        dout_load = 1'b1;
                        state_d   = DONE;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign cnt_run  = (state_q == ADDR) || (state_q == WDATA) || (state_q == RDATA);
    assign cnt_last = (state_q == ADDR) ? ADDR_LAST : DATA_LAST;

    // Bit counter: cleared on entry to a serial phase, then saturates at that phase's last bit
    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            cnt_q <= '0;
        end else if (cnt_clr) begin
            cnt_q <= '0;
        end else if (cnt_run && (cnt_q != cnt_last)) begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    // Capture the host request once so later host activity cannot disturb the transfer
    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            addr_q <= '0;
            rw_q   <= 1'b0;
            din_q  <= '0;
        end else if (latch_en) begin
            addr_q <= bus.m_addr;
            rw_q   <= bus.m_rw;
            din_q  <= bus.m_din;
        end
    end

    // Read result: the eighth sampled bit completes the byte on the edge into DONE
    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            dout_q <= '0;
        end else if (dout_load) begin
            dout_q <= {sr_low, bus.b_bus_in};
        end
    end

    assign bus.b_util    = (state_q == ADDR) || (state_q == WDATA);
    assign bus.b_bus_out = bus.b_util & sr_msb;
    assign bus.b_request = (state_q != IDLE) && (state_q != DONE);
    assign bus.m_dvalid  = (state_q == DONE);
    assign bus.m_busy    = (state_q != IDLE);
    assign bus.m_dout    = dout_q;

endmodule

// File: tb/tb_master.sv
// tb/tb_master.sv - randomized bus-functional bench with arbiter/slave model for master
module tb_master;

    logic clk  = 1'b0;
    logic rstn = 1'b0;

    master_if bif ();

    master u_dut (
        .CLK  (clk),
        .RSTN (rstn),
        .bus  (bif)
    );

    always #5 clk = ~clk;

    int         n_cmp    = 0;
    int         n_bad    = 0;
    logic [7:0] exp_dout = 8'h00;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] outs();
        return {19'b0, bif.b_request, bif.b_bus_out, bif.b_util, bif.m_dout, bif.m_dvalid, bif.m_busy};
    endfunction

    task automatic clear_inputs();
        bif.m_execute = 1'b0;
        bif.m_hold    = 1'b0;
        bif.m_rw      = 1'b0;
        bif.m_addr    = '0;
        bif.m_din     = '0;
        bif.b_grant   = 1'b0;
        bif.b_ack     = 1'b0;
        bif.b_bus_in  = 1'b0;
    endtask

    // One host request played against a reactive arbiter + slave; abort_bit/rst_bit < 0 disable those events
    task automatic txn(input bit rel_rst, input logic rw, input logic [15:0] addr, input logic [7:0] din,
                       input int gdelay, input int adelay, input logic [7:0] rbyte,
                       input int abort_bit, input int rst_bit);
        logic [16:0] hdr;
        logic [7:0]  wd;
        logic [7:0]  dv_dout;
        int nh, nw, phase, wcnt, rbit, gseen, ndv, viol, cyc;
        bit done, aborted, was_reset;
        hdr = '0; wd = '0; dv_dout = '0;
        nh = 0; nw = 0; phase = 0; wcnt = 0; rbit = 0; gseen = 0; ndv = 0; viol = 0; cyc = 0;
        done = 0; aborted = 0; was_reset = 0;

        @(negedge clk);
        bif.m_execute = 1'b1;
        bif.m_hold    = 1'b1;
        bif.m_rw      = rw;
        bif.m_addr    = addr;
        bif.m_din     = din;
        bif.b_grant   = 1'b0;
        bif.b_ack     = 1'b0;
        bif.b_bus_in  = 1'b0;
        if (rel_rst) rstn = 1'b1;

        while (!done && cyc < 300) begin
            @(negedge clk);
            cyc++;
            // host side keeps wiggling; only the values at the start edge may matter
            bif.m_execute = 1'b0;
            bif.m_hold    = 1'($urandom);
            bif.m_rw      = 1'($urandom);
            bif.m_addr    = 16'($urandom);
            bif.m_din     = 8'($urandom);

            if (!bif.b_util && bif.b_bus_out) viol++;
            if (bif.m_busy && !bif.m_dvalid && !bif.b_request) viol++;
            if (!bif.m_busy && bif.b_request) viol++;
            if (bif.m_dvalid) begin
                ndv++;
                dv_dout = bif.m_dout;
            end

            if (bif.b_request && !bif.b_grant && !aborted) begin
                if (bif.b_util) viol++;
                if (gseen >= gdelay) bif.b_grant = 1'b1;
                gseen++;
            end

            case (phase)
                0: if (bif.b_util) begin
                    hdr = {hdr[15:0], bif.b_bus_out};
                    nh++;
                    if (abort_bit == nh - 1) begin
                        bif.b_grant = 1'b0;
                        aborted = 1;
                        phase = 9;
                    end else if (nh == 17) begin
                        phase = 1;
                        wcnt = adelay;
                    end
                end
                1: begin
                    if (bif.b_util) viol++;
                    if (wcnt == 0) begin
                        bif.b_ack = 1'b1;
                        wcnt = 2;
                        phase = 2;
                    end else begin
                        wcnt--;
                    end
                end
                2: begin
                    if (bif.b_util) viol++;
                    wcnt--;
                    if (wcnt == 0) begin
                        bif.b_ack = 1'b0;
                        phase = rw ? 3 : 4;
                    end
                end
                3: if (bif.b_util) begin
                    wd = {wd[6:0], bif.b_bus_out};
                    nw++;
                    if (nw == 8) phase = 5;
                end
                5: begin
                    bif.b_ack = 1'b1;
                    phase = 6;
                end
                6: begin
                    bif.b_ack = 1'b0;
                    phase = 7;
                end
                4: begin
                    if (rbit == rst_bit) begin
                        #2;
                        rstn = 1'b0;
                        #1;
                        chk("rst_async_outs", outs(), 32'h0);
                        exp_dout = 8'h00;
                        was_reset = 1;
                        done = 1;
                    end else begin
                        bif.b_bus_in = rbyte[7 - rbit];
                        rbit++;
                        if (rbit == 8) phase = 7;
                    end
                end
                7: begin
                    bif.b_bus_in = 1'b0;
                    if (!bif.m_busy) done = 1;
                end
                9: begin
                    chk("abort_busy", {31'b0, bif.m_busy}, 32'h0);
                    chk("abort_req", {31'b0, bif.b_request}, 32'h0);
                    done = 1;
                end
                default: done = 1;
            endcase
        end

        clear_inputs();
        if (!done) begin
            chk("timeout", 32'h0, 32'h1);
            rstn = 1'b0;
            exp_dout = 8'h00;
            @(negedge clk);
            rstn = 1'b1;
        end else if (was_reset) begin
            chk("rst_dvalid_cnt", ndv, 0);
        end else if (aborted) begin
            chk("abort_dvalid_cnt", ndv, 0);
        end else begin
            chk("header", {15'b0, hdr}, {15'b0, addr, rw});
            if (rw) begin
                chk("wdata", {24'b0, wd}, {24'b0, din});
            end else begin
                exp_dout = rbyte;
                chk("rdata_at_dvalid", {24'b0, dv_dout}, {24'b0, rbyte});
            end
            chk("dvalid_cnt", ndv, 1);
        end
        chk("protocol_viol", viol, 0);
        chk("dout_hold", {24'b0, bif.m_dout}, {24'b0, exp_dout});
    endtask

    logic        r_rw;
    logic [15:0] r_addr;
    logic [7:0]  r_din;
    logic [7:0]  r_byte;
    int          r_gd;
    int          r_ad;
    int          r_ab;

    initial begin
        clear_inputs();
        rstn = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_outs", outs(), 32'h0);

        // write 0x1234 <- 0xAD starting on the first edge out of reset, grant right away
        txn(1, 1'b1, 16'h1234, 8'hAD, 0, 1, 8'h00, -1, -1);
        // read 0x1234, slave returns 10101101
        txn(0, 1'b0, 16'h1234, 8'h00, 0, 0, 8'hAD, -1, -1);
        // grant withheld for 5 request cycles
        txn(0, 1'b1, 16'hBEEF, 8'h5A, 5, 2, 8'h00, -1, -1);
        // grant dropped on header bit 8
        txn(0, 1'b0, 16'hF00F, 8'h00, 1, 0, 8'h3C, 8, -1);

        // execute without hold never leaves IDLE
        @(negedge clk);
        bif.m_execute = 1'b1;
        bif.m_hold    = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("nohold_req", {31'b0, bif.b_request}, 32'h0);
            chk("nohold_busy", {31'b0, bif.m_busy}, 32'h0);
        end
        clear_inputs();

        // reset asserted while the read byte is arriving
        txn(0, 1'b0, 16'h0F0F, 8'h00, 0, 1, 8'hC3, -1, 3);

        for (int i = 0; i < 24; i++) begin
            r_rw   = 1'($urandom);
            r_addr = 16'($urandom);
            r_din  = 8'($urandom);
            r_byte = 8'($urandom);
            r_gd   = int'($urandom_range(0, 4));
            r_ad   = int'($urandom_range(0, 3));
            r_ab   = ($urandom_range(0, 5) == 0) ? int'($urandom_range(0, 16)) : -1;
            txn((i == 0), r_rw, r_addr, r_din, r_gd, r_ad, r_byte, r_ab, -1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: observed no finish expected finish");
        $fatal(1, "watchdog expired");
    end

endmodule
